// File: rtl/sdr_ctrl_pkg.sv
// Shared definitions for the tuning command parser: opcodes, FSM states and
// payload-length decoding.
package sdr_ctrl_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    localparam logic [3:0] OP_SET_INC   = 4'd1;
    localparam logic [3:0] OP_STEP_UP   = 4'd2;
    localparam logic [3:0] OP_STEP_DN   = 4'd3;
    localparam logic [3:0] OP_SET_STEP  = 4'd4;
    localparam logic [3:0] OP_SET_DECIM = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_PAYLOAD,
        ST_CHK,
        ST_APPLY
    } state_t;

    function automatic logic [3:0] payload_len(input logic [3:0] op, input int phase_w);
        case (op)
            OP_SET_INC, OP_SET_STEP: payload_len = 4'(phase_w / 8);
            OP_SET_DECIM:            payload_len = 4'd2;
            default:                 payload_len = 4'd0;
        endcase
    endfunction

    function automatic logic op_known(input logic [3:0] op);
        return (op >= OP_SET_INC) && (op <= OP_SET_DECIM);
    endfunction

    // Opcodes that address a channel and touch its increment.
    function automatic logic op_is_inc(input logic [3:0] op);
        return (op >= OP_SET_INC) && (op <= OP_STEP_DN);
    endfunction

endpackage

// File: rtl/sdr_gap_timer.sv
// Inter-byte gap counter: cleared by each received byte, counts while enabled,
// flags a timeout once TIMEOUT_CLKS quiet cycles have elapsed.
module sdr_gap_timer #(
    parameter int TIMEOUT_CLKS = 136000
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] cnt_reg;

    // Saturates at LAST so a stalled enable never wraps into a false restart.
    always_ff @(posedge clk) begin
        if (srst || clr || !en) begin
            cnt_reg <= '0;
        end else if (cnt_reg != LAST) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign timeout = en && (cnt_reg == LAST);

endmodule

// File: rtl/sdr_tune_ctrl.sv
// Framed UART command parser producing per-channel NCO increments, a tuning
// step and the CIC decimation ratio.
module sdr_tune_ctrl
    import sdr_ctrl_pkg::*;
#(
    parameter int          PHASE_W      = 64,
    parameter int          NUM_CH       = 2,
    parameter logic [63:0] RESET_INC    = 64'h1E25D3E862E4518,
    parameter logic [63:0] RESET_STEP   = 64'h45641C6E59DF0,
    parameter logic [15:0] RESET_DECIM  = 16'd16384,
    parameter int          TIMEOUT_CLKS = 136000,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_DEFAULT
) (
    input  logic                      osc_clk,
    input  logic                      rst,
    input  logic                      rx_dv,
    input  logic [7:0]                rx_byte,
    output logic [NUM_CH*PHASE_W-1:0] phase_inc,
    output logic [NUM_CH-1:0]         inc_upd,
    output logic [15:0]               decim_ratio,
    output logic                      cmd_ok,
    output logic                      frame_err,
    output logic                      busy
);

    localparam logic [PHASE_W-1:0] RESET_INC_W  = RESET_INC[PHASE_W-1:0];
    localparam logic [PHASE_W-1:0] RESET_STEP_W = RESET_STEP[PHASE_W-1:0];

    state_t               state_reg, state_next;
    logic [3:0]           op_reg, ch_reg, byte_cnt_reg;
    logic [7:0]           chk_reg;
    logic [PHASE_W-1:0]   shift_reg, step_reg;
    logic [15:0]          decim_reg;
    logic                 cmd_ok_reg, frame_err_reg;
    logic                 load_cmd, shift_now, err_now, apply_now, timeout;

    sdr_gap_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_gap_timer (
        .clk     (osc_clk),
        .srst    (rst),
        .clr     (rx_dv),
        .en      (busy),
        .timeout (timeout)
    );

    always_ff @(posedge osc_clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load_cmd   = 1'b0;
        shift_now  = 1'b0;
        err_now    = 1'b0;
        apply_now  = 1'b0;
        // Timeout wins over a byte arriving on the same cycle; APPLY is exempt
        // so a frame that already passed its checksum is always committed.
        if (timeout && (state_reg inside {ST_CMD, ST_PAYLOAD, ST_CHK})) begin
            err_now    = 1'b1;
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (rx_dv && rx_byte == SYNC_BYTE) state_next = ST_CMD;
                end
                ST_CMD: begin
                    if (rx_dv) begin
                        if (!op_known(rx_byte[7:4]) ||
                            (op_is_inc(rx_byte[7:4]) && int'(rx_byte[3:0]) >= NUM_CH)) begin
                            err_now    = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            load_cmd   = 1'b1;
                            state_next = (payload_len(rx_byte[7:4], PHASE_W) == 4'd0) ? ST_CHK : ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_dv) begin
                        shift_now = 1'b1;
                        if (byte_cnt_reg == payload_len(op_reg, PHASE_W) - 4'd1) state_next = ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (rx_dv) begin
                        if (rx_byte != chk_reg ||
                            (op_reg == OP_SET_DECIM && shift_reg[15:0] == 16'd0)) begin
                            err_now    = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            state_next = ST_APPLY;
                        end
                    end
                end
                ST_APPLY: begin
                    apply_now  = 1'b1;
                    state_next = (rx_dv && rx_byte == SYNC_BYTE) ? ST_CMD : ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge osc_clk) begin
        if (rst) begin
            op_reg        <= '0;
            ch_reg        <= '0;
            byte_cnt_reg  <= '0;
            chk_reg       <= '0;
            shift_reg     <= '0;
            step_reg      <= RESET_STEP_W;
            decim_reg     <= RESET_DECIM;
            cmd_ok_reg    <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            cmd_ok_reg    <= apply_now;
            frame_err_reg <= err_now;
            if (load_cmd) begin
                op_reg       <= rx_byte[7:4];
                ch_reg       <= rx_byte[3:0];
                chk_reg      <= rx_byte;
                byte_cnt_reg <= '0;
            end
            if (shift_now) begin
                shift_reg    <= {shift_reg[PHASE_W-9:0], rx_byte};
                chk_reg      <= chk_reg ^ rx_byte;
                byte_cnt_reg <= byte_cnt_reg + 4'd1;
            end
            if (apply_now && op_reg == OP_SET_STEP)  step_reg  <= shift_reg;
            if (apply_now && op_reg == OP_SET_DECIM) decim_reg <= shift_reg[15:0];
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [PHASE_W-1:0] inc_reg;
        logic               upd_reg;
        logic               hit;

        assign hit = apply_now && op_is_inc(op_reg) && (ch_reg == 4'(gi));

        always_ff @(posedge osc_clk) begin
            if (rst) begin
                inc_reg <= RESET_INC_W;
                upd_reg <= 1'b0;
            end else begin
                upd_reg <= hit;
                if (hit) begin
                    case (op_reg)
                        OP_SET_INC: inc_reg <= shift_reg;
                        OP_STEP_UP: inc_reg <= inc_reg + step_reg;
                        default:    inc_reg <= inc_reg - step_reg;
                    endcase
                end
            end
        end

        assign phase_inc[gi*PHASE_W +: PHASE_W] = inc_reg;
        assign inc_upd[gi]                      = upd_reg;
    end

    assign decim_ratio = decim_reg;
    assign cmd_ok      = cmd_ok_reg;
    assign frame_err   = frame_err_reg;
    assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_sdr_tune_ctrl.sv
// Directed frames against a frame-level model of the tuning command parser;
// outputs are compared to the model on every cycle.
module tb_sdr_tune_ctrl;

    localparam int PW  = 64;
    localparam int NCH = 2;
    localparam int TO  = 200;
    localparam logic [63:0] R_INC  = 64'h1E25D3E862E4518;
    localparam logic [63:0] R_STEP = 64'h45641C6E59DF0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_dv = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic [NCH*PW-1:0] phase_inc;
    logic [NCH-1:0]    inc_upd;
    logic [15:0]       decim_ratio;
    logic              cmd_ok, frame_err, busy;

    sdr_tune_ctrl #(.PHASE_W(PW), .NUM_CH(NCH), .TIMEOUT_CLKS(TO)) dut (
        .osc_clk     (clk),
        .rst         (rst),
        .rx_dv       (rx_dv),
        .rx_byte     (rx_byte),
        .phase_inc   (phase_inc),
        .inc_upd     (inc_upd),
        .decim_ratio (decim_ratio),
        .cmd_ok      (cmd_ok),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Frame-level model state and the single pending outcome of the last frame.
    logic [63:0]    m_inc [NCH];
    logic [63:0]    m_step;
    logic [15:0]    m_decim;
    int             ev_cyc = -1;
    bit             ev_ok, ev_err;
    logic [NCH-1:0] ev_mask;
    int             ev_op, ev_ch;
    logic [63:0]    ev_val;
    bit             chk_en = 1'b0;
    bit             e_ok, e_err;
    logic [NCH-1:0] e_upd;
    logic [7:0]     fq [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) m_inc[i] = R_INC;
        m_step  = R_STEP;
        m_decim = 16'd16384;
        ev_cyc  = -1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            e_ok  = 1'b0;
            e_err = 1'b0;
            e_upd = '0;
            if (cyc == ev_cyc) begin
                e_ok  = ev_ok;
                e_err = ev_err;
                e_upd = ev_mask;
                if (ev_ok) begin
                    case (ev_op)
                        1: m_inc[ev_ch] = ev_val;
                        2: m_inc[ev_ch] = m_inc[ev_ch] + m_step;
                        3: m_inc[ev_ch] = m_inc[ev_ch] - m_step;
                        4: m_step = ev_val;
                        default: m_decim = ev_val[15:0];
                    endcase
                end
            end
            check("inc_ch0", phase_inc[63:0], m_inc[0]);
            check("inc_ch1", phase_inc[127:64], m_inc[1]);
            check("decim", 64'(decim_ratio), 64'(m_decim));
            check("cmd_ok", 64'(cmd_ok), 64'(e_ok));
            check("frame_err", 64'(frame_err), 64'(e_err));
            check("inc_upd", 64'(inc_upd), 64'(e_upd));
        end
    end

    // Sends fq one byte per cycle, then predicts the frame outcome from its bytes.
    task automatic run_frame(input string name, input bit hold);
        int n, op, ch, len, bc[$];
        logic [7:0]  x;
        logic [63:0] p;
        n = fq.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx_dv = 1'b1; rx_byte = fq[i];
            bc.push_back(cyc);
        end
        if (!hold) begin
            @(posedge clk); #1;
            rx_dv = 1'b0;
        end
        op  = int'(fq[1][7:4]);
        ch  = int'(fq[1][3:0]);
        len = (op == 1 || op == 4) ? PW / 8 : (op == 5) ? 2 : 0;
        ev_ok = 1'b0; ev_err = 1'b1; ev_mask = '0; ev_op = op; ev_ch = ch;
        if (op < 1 || op > 5 || (op <= 3 && ch >= NCH)) begin
            ev_cyc = bc[1] + 1;
        end else if (n < 3 + len) begin
            ev_cyc = bc[n-1] + TO + 1;
        end else begin
            x = 8'h00; p = 64'h0;
            for (int i = 1; i < 2 + len; i++) x ^= fq[i];
            for (int i = 0; i < len; i++) p = {p[55:0], fq[2+i]};
            ev_val = p;
            if (x != fq[2+len] || (op == 5 && p[15:0] == 16'h0)) begin
                ev_cyc = bc[2+len] + 1;
            end else begin
                ev_cyc  = bc[2+len] + 2;
                ev_ok   = 1'b1;
                ev_err  = 1'b0;
                ev_mask = (op <= 3) ? NCH'(1 << ch) : '0;
            end
        end
        $display("frame %-12s bytes=%0d cmd=%h expect_ok=%0d expect_err=%0d at_cycle=%0d",
                 name, n, fq[1], ev_ok, ev_err, ev_cyc);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; rx_dv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();
        repeat (100) @(posedge clk);
        #1;
        check("rst_inc0", phase_inc[63:0], 64'h01E25D3E862E4518);
        check("rst_inc1", phase_inc[127:64], 64'h01E25D3E862E4518);
        check("rst_decim", 64'(decim_ratio), 64'd16384);
        check("rst_busy", 64'(busy), 64'd0);

        fq = '{8'hA5, 8'h10, 8'h01, 8'h04, 8'h37, 8'h6A, 8'h9D, 8'hD1, 8'h04, 8'h37, 8'h37};
        run_frame("set_inc_ch0", 1'b0);
        settle();
        check("t2_inc0", phase_inc[63:0], 64'h0104376A9DD10437);
        check("t2_inc1", phase_inc[127:64], 64'h01E25D3E862E4518);

        fq = '{8'hA5, 8'h10, 8'h01, 8'h04, 8'h37, 8'h6A, 8'h9D, 8'hD1, 8'h04, 8'h37, 8'h38};
        run_frame("bad_chk", 1'b0);
        settle();
        check("t3_inc0", phase_inc[63:0], 64'h0104376A9DD10437);

        fq = '{8'hA5, 8'h11, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h11};
        run_frame("set_inc_ch1", 1'b0);
        fq = '{8'hA5, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h42};
        run_frame("set_step", 1'b0);
        fq = '{8'hA5, 8'h21, 8'h21};
        run_frame("step_up_ch1", 1'b0);
        settle();
        check("t4_wrap_up", phase_inc[127:64], 64'h0000000000000001);
        fq = '{8'hA5, 8'h31, 8'h31};
        run_frame("step_dn_ch1", 1'b0);
        settle();
        check("t4_wrap_dn", phase_inc[127:64], 64'hFFFFFFFFFFFFFFFF);

        fq = '{8'hA5, 8'h20, 8'h20};
        run_frame("b2b_up_ch0", 1'b1);
        fq = '{8'hA5, 8'h30, 8'h30};
        run_frame("b2b_dn_ch0", 1'b0);
        settle();
        check("b2b_inc0", phase_inc[63:0], 64'h0104376A9DD10437);

        fq = '{8'hA5, 8'h10, 8'h11, 8'h22, 8'h33};
        run_frame("timeout", 1'b0);
        check("t5_busy_mid", 64'(busy), 64'd1);
        repeat (TO + 5) @(posedge clk);
        #1;
        check("t5_busy_after", 64'(busy), 64'd0);
        check("t5_inc0", phase_inc[63:0], 64'h0104376A9DD10437);
        fq = '{8'hA5, 8'h50, 8'h10, 8'h00, 8'h40};
        run_frame("set_decim", 1'b0);
        settle();
        check("t5_decim", 64'(decim_ratio), 64'd4096);
        fq = '{8'hA5, 8'h50, 8'h00, 8'h00, 8'h50};
        run_frame("decim_zero", 1'b0);
        settle();
        check("decim_zero_kept", 64'(decim_ratio), 64'd4096);
        fq = '{8'hA5, 8'h70};
        run_frame("bad_opcode", 1'b0);
        settle();

        fq = '{8'hA5, 8'h1F};
        run_frame("bad_channel", 1'b0);
        settle();
        check("t6_busy", 64'(busy), 64'd0);

        fq = '{8'hA5, 8'h10, 8'h01, 8'h02, 8'h03};
        run_frame("reset_cut", 1'b0);
        do_reset();
        #1;
        check("t6_rst_inc0", phase_inc[63:0], 64'h01E25D3E862E4518);
        check("t6_rst_inc1", phase_inc[127:64], 64'h01E25D3E862E4518);
        check("t6_rst_decim", 64'(decim_ratio), 64'd16384);
        check("t6_rst_busy", 64'(busy), 64'd0);
        fq = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h15};
        run_frame("post_reset", 1'b0);
        settle();
        check("t6_post_inc0", phase_inc[63:0], 64'h0000000000000005);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
